// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel gradient pipeline.
// The gradient width is derived so that +/-4*(2^PIXEL_W-1) always fits.
package sobel_pkg;

  localparam int PIXEL_W_DEF = 8;

  // Weights along one kernel row/column: outer taps 1, centre tap 2.
  localparam int K_OUTER  = 1;
  localparam int K_CENTER = 2;

  typedef enum logic [1:0] {
    MODE_GX   = 2'd0,
    MODE_GY   = 2'd1,
    MODE_BOTH = 2'd2,
    MODE_EDGE = 2'd3
  } mode_t;

  function automatic int grad_w(input int pixel_w);
    return pixel_w + 3;
  endfunction

endpackage

// File: rtl/sobel_kernel_sum.sv
// Weighted 1-2-1 sum of three pixels (a + 2b + c), zero-extended to OUT_W.
module sobel_kernel_sum
  import sobel_pkg::*;
#(
  parameter int IN_W  = PIXEL_W_DEF,
  parameter int OUT_W = grad_w(PIXEL_W_DEF)
) (
  input  logic [IN_W-1:0]  i_a,
  input  logic [IN_W-1:0]  i_b,
  input  logic [IN_W-1:0]  i_c,
  output logic [OUT_W-1:0] o_sum
);

  logic [OUT_W-1:0] w_a;
  logic [OUT_W-1:0] w_b;
  logic [OUT_W-1:0] w_c;

  assign w_a   = OUT_W'(i_a);
  assign w_b   = OUT_W'(i_b);
  assign w_c   = OUT_W'(i_c);
  assign o_sum = w_a * OUT_W'(K_OUTER) + w_b * OUT_W'(K_CENTER) + w_c * OUT_W'(K_OUTER);

endmodule

// File: rtl/sobel_gradient_pipe.sv
// Three-stage Sobel gradient unit: row/column sums -> gx/gy -> masked magnitude,
// clamp and edge flag. The whole pipe advances together when the output slot frees.
module sobel_gradient_pipe
  import sobel_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int GRAD_W  = grad_w(PIXEL_W),
  parameter bit SAT_OUT = 1'b1
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [9*PIXEL_W-1:0]      i_window,
  input  logic [1:0]                i_mode,
  input  logic [PIXEL_W-1:0]        i_threshold,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic signed [GRAD_W-1:0]  o_gx,
  output logic signed [GRAD_W-1:0]  o_gy,
  output logic [GRAD_W-1:0]         o_mag,
  output logic [PIXEL_W-1:0]        o_edge_pix,
  output logic                      o_edge_flag
);

  // Handshake: a transfer happens on a clk edge where valid & ready are both 1.
  // Ready is adv = !out_valid | out_ready; stalls freeze every stage, bubbles included.
  localparam logic [GRAD_W-1:0] PIX_MAX = GRAD_W'({PIXEL_W{1'b1}});

  logic                      w_adv;
  logic [PIXEL_W-1:0]        w_px [9];
  logic [GRAD_W-1:0]         w_sum [6];
  logic                      w_unused_mid;

  logic                      r_s1_v;
  logic [GRAD_W-1:0]         r_sum [6];
  mode_t                     r_s1_mode;
  logic [PIXEL_W-1:0]        r_s1_thr;

  logic                      r_s2_v;
  logic signed [GRAD_W-1:0]  r_s2_gx;
  logic signed [GRAD_W-1:0]  r_s2_gy;
  mode_t                     r_s2_mode;
  logic [PIXEL_W-1:0]        r_s2_thr;

  logic                      r_s3_v;
  logic signed [GRAD_W-1:0]  r_gx;
  logic signed [GRAD_W-1:0]  r_gy;
  logic [GRAD_W-1:0]         r_mag;
  logic [PIXEL_W-1:0]        r_edge_pix;
  logic                      r_edge_flag;

  logic signed [GRAD_W-1:0]  w_gx_m;
  logic signed [GRAD_W-1:0]  w_gy_m;
  logic [GRAD_W-1:0]         w_abs_gx;
  logic [GRAD_W-1:0]         w_abs_gy;
  logic [GRAD_W-1:0]         w_mag;
  logic [PIXEL_W-1:0]        w_edge_pix;
  logic                      w_edge_flag;

  assign w_adv      = !r_s3_v || i_out_ready;
  assign o_in_ready = w_adv;

  // Sums 0..2 are rows 0..2, sums 3..5 are columns 0..2.
  for (genvar k = 0; k < 9; k++) begin : g_px
    assign w_px[k] = i_window[k*PIXEL_W +: PIXEL_W];
  end

  for (genvar k = 0; k < 3; k++) begin : g_sum
    sobel_kernel_sum #(.IN_W(PIXEL_W), .OUT_W(GRAD_W)) u_row (
      .i_a(w_px[3*k]), .i_b(w_px[3*k+1]), .i_c(w_px[3*k+2]), .o_sum(w_sum[k])
    );
    sobel_kernel_sum #(.IN_W(PIXEL_W), .OUT_W(GRAD_W)) u_col (
      .i_a(w_px[k]), .i_b(w_px[k+3]), .i_c(w_px[k+6]), .o_sum(w_sum[k+3])
    );
  end

  // Middle row and column carry zero weight in both Sobel kernels.
  assign w_unused_mid = ^{r_sum[1], r_sum[4]};

  always_comb begin
    w_gx_m      = (r_s2_mode == MODE_GY) ? '0 : r_s2_gx;
    w_gy_m      = (r_s2_mode == MODE_GX) ? '0 : r_s2_gy;
    w_abs_gx    = w_gx_m[GRAD_W-1] ? $unsigned(-w_gx_m) : $unsigned(w_gx_m);
    w_abs_gy    = w_gy_m[GRAD_W-1] ? $unsigned(-w_gy_m) : $unsigned(w_gy_m);
    w_mag       = w_abs_gx + w_abs_gy;
    w_edge_flag = (r_s2_mode == MODE_EDGE) && (w_mag >= GRAD_W'(r_s2_thr));
    w_edge_pix  = w_mag[PIXEL_W-1:0];
    if (SAT_OUT && (w_mag > PIX_MAX)) begin
      w_edge_pix = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_s1_v      <= 1'b0;
      for (int k = 0; k < 6; k++) r_sum[k] <= '0;
      r_s1_mode   <= MODE_GX;
      r_s1_thr    <= '0;
      r_s2_v      <= 1'b0;
      r_s2_gx     <= '0;
      r_s2_gy     <= '0;
      r_s2_mode   <= MODE_GX;
      r_s2_thr    <= '0;
      r_s3_v      <= 1'b0;
      r_gx        <= '0;
      r_gy        <= '0;
      r_mag       <= '0;
      r_edge_pix  <= '0;
      r_edge_flag <= 1'b0;
    end else if (w_adv) begin
      r_s1_v      <= i_in_valid;
      for (int k = 0; k < 6; k++) r_sum[k] <= w_sum[k];
      r_s1_mode   <= mode_t'(i_mode);
      r_s1_thr    <= i_threshold;
      r_s2_v      <= r_s1_v;
      r_s2_gx     <= $signed(r_sum[5]) - $signed(r_sum[3]);
      r_s2_gy     <= $signed(r_sum[2]) - $signed(r_sum[0]);
      r_s2_mode   <= r_s1_mode;
      r_s2_thr    <= r_s1_thr;
      r_s3_v      <= r_s2_v;
      r_gx        <= w_gx_m;
      r_gy        <= w_gy_m;
      r_mag       <= w_mag;
      r_edge_pix  <= w_edge_pix;
      r_edge_flag <= w_edge_flag;
    end
  end

  assign o_out_valid = r_s3_v;
  assign o_gx        = r_gx;
  assign o_gy        = r_gy;
  assign o_mag       = r_mag;
  assign o_edge_pix  = r_edge_pix;
  assign o_edge_flag = r_edge_flag;

endmodule
